// File: rtl/shift_reg_window.sv
// Streaming 2-D sliding-window generator: a tap chain spanning (block_height-1) image lines
// plus block_width pixels, with the block_width x block_height neighbourhood exposed as one bus.
module shift_reg_window #(
  parameter int unsigned pixel_depth  = 8,
  parameter int unsigned frame_width  = 200,
  parameter int unsigned block_width  = 3,
  parameter int unsigned block_height = 3
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic                                              en,
  input  logic [pixel_depth-1:0]                            pix_in,
  output logic [pixel_depth*block_width*block_height-1:0]   window
);

  localparam int unsigned TapLen = (block_height - 1) * frame_width + block_width;

  // tap_q[0] is the newest sample; tap_q[k] is k enabled edges older.
  logic [pixel_depth-1:0] tap_q [TapLen];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < TapLen; k++) begin
        tap_q[k] <= '0;
      end
    end else if (en) begin
      tap_q[0] <= pix_in;
      for (int k = 1; k < TapLen; k++) begin
        tap_q[k] <= tap_q[k-1];
      end
    end
  end

  // Row r is r lines (frame_width samples) older; column c is c samples older within the row.
  for (genvar r = 0; r < block_height; r++) begin : g_row
    for (genvar c = 0; c < block_width; c++) begin : g_col
      assign window[(r*block_width+c)*pixel_depth +: pixel_depth] = tap_q[r*frame_width+c];
    end
  end

endmodule

// File: tb/tb_shift_reg_window.sv
// Directed bench for shift_reg_window: default 3x3 window, a 1x1 16-bit pipeline register,
// and a narrow 4-pixel-wide frame that exercises line wrap.
module tb_shift_reg_window;

  logic        clk;
  logic        rst;

  logic        en_a;
  logic [7:0]  pix_a;
  logic [71:0] win_a;

  logic        en_b;
  logic [15:0] pix_b;
  logic [15:0] win_b;

  logic        en_c;
  logic [7:0]  pix_c;
  logic [71:0] win_c;

  int checks = 0;
  int errors = 0;

  shift_reg_window #(
    .pixel_depth(8), .frame_width(200), .block_width(3), .block_height(3)
  ) u_dut_a (
    .clk(clk), .rst(rst), .en(en_a), .pix_in(pix_a), .window(win_a)
  );

  shift_reg_window #(
    .pixel_depth(16), .frame_width(200), .block_width(1), .block_height(1)
  ) u_dut_b (
    .clk(clk), .rst(rst), .en(en_b), .pix_in(pix_b), .window(win_b)
  );

  shift_reg_window #(
    .pixel_depth(8), .frame_width(4), .block_width(3), .block_height(3)
  ) u_dut_c (
    .clk(clk), .rst(rst), .en(en_c), .pix_in(pix_c), .window(win_c)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled on the following falling edge.
  task automatic push_a(input logic [7:0] p);
    en_a  = 1'b1;
    pix_a = p;
    @(posedge clk);
    @(negedge clk);
    en_a  = 1'b0;
  endtask

  task automatic push_b(input logic [15:0] p);
    en_b  = 1'b1;
    pix_b = p;
    @(posedge clk);
    @(negedge clk);
    en_b  = 1'b0;
  endtask

  task automatic push_c(input logic [7:0] p);
    en_c  = 1'b1;
    pix_c = p;
    @(posedge clk);
    @(negedge clk);
    en_c  = 1'b0;
  endtask

  task automatic check_ramp_450(input string pfx);
    int exp_a[9];
    exp_a = '{194, 193, 192, 250, 249, 248, 50, 49, 48};
    for (int e = 0; e < 9; e++) begin
      check($sformatf("%s_el%0d", pfx, e), 32'(win_a[e*8 +: 8]), exp_a[e]);
    end
  endtask

  initial begin
    int exp_c[9];
    exp_c = '{20, 19, 18, 16, 15, 14, 12, 11, 10};

    rst   = 1'b1;
    en_a  = 1'b0; pix_a = 8'h00;
    en_b  = 1'b0; pix_b = 16'h0000;
    en_c  = 1'b0; pix_c = 8'h00;
    @(negedge clk);
    @(negedge clk);
    check("reset_win_a", 32'(|win_a), 32'd0);
    check("reset_win_b", 32'(win_b), 32'd0);
    rst = 1'b0;

    // 1x1 pipeline register
    push_b(16'hBEEF);
    check("b_beef", 32'(win_b), 32'hBEEF);
    pix_b = 16'h5555;
    repeat (3) @(negedge clk);
    check("b_stall", 32'(win_b), 32'hBEEF);
    push_b(16'h1234);
    check("b_1234", 32'(win_b), 32'h1234);

    // Narrow frame: window wraps into previous line
    for (int n = 0; n <= 20; n++) begin
      push_c(n[7:0]);
    end
    for (int e = 0; e < 9; e++) begin
      check($sformatf("wrap_el%0d", e), 32'(win_c[e*8 +: 8]), exp_c[e]);
    end

    // Ramp fill on the default geometry, with partial-fill checks at edge 5
    for (int n = 0; n <= 450; n++) begin
      push_a(n[7:0]);
      if (n == 5) begin
        check("part_el0", 32'(win_a[7:0]), 32'd5);
        check("part_el1", 32'(win_a[15:8]), 32'd4);
        check("part_el2", 32'(win_a[23:16]), 32'd3);
        for (int e = 3; e < 9; e++) begin
          check($sformatf("part_el%0d", e), 32'(win_a[e*8 +: 8]), 32'd0);
        end
      end
    end
    check_ramp_450("ramp");

    // Stall: en low with changing pix_in must not move the window
    for (int i = 0; i < 7; i++) begin
      pix_a = 8'(8'hA0 + i);
      @(negedge clk);
    end
    check_ramp_450("stall");
    push_a(8'd195);
    check("resume_el0", 32'(win_a[7:0]), 32'd195);
    check("resume_el1", 32'(win_a[15:8]), 32'd194);
    check("resume_el3", 32'(win_a[31:24]), 32'd251);
    check("resume_el8", 32'(win_a[71:64]), 32'd49);

    // Asynchronous reset between edges
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_a", 32'(|win_a), 32'd0);
    check("async_rst_c", 32'(|win_c), 32'd0);
    @(negedge clk);
    pix_a = 8'h77;
    en_a  = 1'b1;
    @(negedge clk);
    en_a  = 1'b0;
    check("rst_hold_a", 32'(|win_a), 32'd0);
    rst = 1'b0;
    push_a(8'h5A);
    check("post_rst_el0", 32'(win_a[7:0]), 32'h5A);
    check("post_rst_rest", 32'(|win_a[71:8]), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
